// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file and its busy-bit scoreboard.
// Modules import this so register addressing stays consistent.
package wb_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits: the issue stage sets them, writeback commits clear them.
// A same-cycle set beats a clear, and a clear is visible on the read ports immediately.
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int NREG = wb_regfile_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            rs1_clr_byp;
  logic            rs2_clr_byp;

  // Clear applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign rs1_clr_byp = clr_en && (clr_rd == rs1_addr) && !(set_en && (set_rd == rs1_addr));
  assign rs2_clr_byp = clr_en && (clr_rd == rs2_addr) && !(set_en && (set_rd == rs2_addr));

  assign rs1_busy = busy[rs1_addr] & ~rs1_clr_byp;
  assign rs2_busy = busy[rs2_addr] & ~rs2_clr_byp;

endmodule

// File: rtl/wb_regfile.sv
// Pipeline register file: writeback commit port, two combinational read ports with
// same-cycle write bypass, busy-bit scoreboard and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = wb_regfile_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  iss_en,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [31:0]           wb_count
);

  // WB and issue are fire-and-forget: wb_en commits only when Stall is low (a held WB
  // entry is not re-committed), while iss_en takes effect every cycle it is high.
  logic                  commit;
  logic                  iss_set;
  logic [DATA_W-1:0]     regs [NREG];

  assign commit  = wb_en && !Stall && (wb_rd != ZERO_REG);
  assign iss_set = iss_en && (iss_rd != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        wb_count <= '0;
    else if (commit) wb_count <= wb_count + 32'd1;
  end

  // Bypass is purely combinational, so it stays live even while reset is held.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != ZERO_REG)
      rs1_data = (commit && (rs1_addr == wb_rd)) ? wb_data : regs[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != ZERO_REG)
      rs2_data = (commit && (rs2_addr == wb_rd)) ? wb_data : regs[rs2_addr];
  end

  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_set),
    .set_rd   (iss_rd),
    .clr_en   (commit),
    .clr_rd   (wb_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized plus directed bench for wb_regfile against an array/bit-vector reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] wb_count;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_count;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .Stall    (Stall),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .wb_count (wb_count)
  );

  // ---------------- reference model ----------------
  function automatic bit m_commit();
    return wb_en && !Stall && (wb_rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_commit() && a == wb_rd) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy_rd(input logic [4:0] a);
    if (m_commit() && a == wb_rd && !(iss_en && iss_rd == a)) return 32'd0;
    return {31'd0, m_busy[a]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_count = 32'd0;
  endtask

  task automatic m_clock();
    if (m_commit()) begin
      m_regs[wb_rd] = wb_data;
      m_busy[wb_rd] = 1'b0;
      m_count       = m_count + 32'd1;
    end
    if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_q.push_back(m_read(rs1_addr));
    exp_q.push_back(m_read(rs2_addr));
    exp_q.push_back(m_busy_rd(rs1_addr));
    exp_q.push_back(m_busy_rd(rs2_addr));
    exp_q.push_back(m_count);
    check("rs1_data", rs1_data, exp_q.pop_front());
    check("rs2_data", rs2_data, exp_q.pop_front());
    check("rs1_busy", {31'd0, rs1_busy}, exp_q.pop_front());
    check("rs2_busy", {31'd0, rs2_busy}, exp_q.pop_front());
    check("wb_count", wb_count, exp_q.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic en, input logic [4:0] rd, input logic [31:0] data,
                       input logic stall, input logic ien, input logic [4:0] ird,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb_en = en;  wb_rd = rd;  wb_data = data;  Stall = stall;
    iss_en = ien; iss_rd = ird; rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst) m_clock();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #3;
    check("reset_rs1_data", rs1_data, 32'd0);
    check("reset_count", wb_count, 32'd0);
    check("reset_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);

    // commit attempted during reset: bypass visible, nothing stored
    drive(1, 4, 32'h1234_5678, 0, 1, 4, 4, 4);
    sample();
    check("reset_bypass", rs1_data, 32'h1234_5678);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    sample();
    rst = 1'b1;
    clock_edge();

    // write then read
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0);
    sample();
    check("wr_bypass", rs1_data, 32'hDEAD_BEEF);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    sample();
    check("wr_array", rs1_data, 32'hDEAD_BEEF);
    check("wr_count", wb_count, 32'd1);
    clock_edge();

    // stall hold
    drive(1, 7, 32'h22, 0, 0, 0, 7, 0);
    sample(); clock_edge();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 32'h11, 1, 0, 0, 7, 0);
      sample();
      check("stall_no_bypass", rs1_data, 32'h22);
      clock_edge();
    end
    drive(1, 7, 32'h11, 0, 0, 0, 7, 0);
    sample(); clock_edge();
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    sample();
    check("stall_data", rs1_data, 32'h11);
    check("stall_count", wb_count, 32'd3);
    clock_edge();

    // x0 protection
    drive(1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
    sample();
    check("x0_data", rs1_data, 32'd0);
    check("x0_busy", {31'd0, rs1_busy}, 32'd0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check("x0_count", wb_count, 32'd3);
    check("x0_busy_after", {31'd0, rs1_busy}, 32'd0);
    clock_edge();

    // scoreboard race: set wins over same-cycle clear
    drive(0, 0, 0, 0, 1, 3, 0, 3);
    sample(); clock_edge();
    drive(1, 3, 32'hA5A5_0003, 0, 1, 3, 0, 3);
    sample(); clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 3);
    sample();
    check("race_busy", {31'd0, rs2_busy}, 32'd1);
    check("race_data", rs2_data, 32'hA5A5_0003);
    clock_edge();

    // clear bypass
    drive(0, 0, 0, 0, 1, 9, 9, 0);
    sample(); clock_edge();
    drive(1, 9, 32'h99, 0, 0, 0, 9, 0);
    sample();
    check("clr_byp_busy", {31'd0, rs1_busy}, 32'd0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    sample();
    check("clr_after_busy", {31'd0, rs1_busy}, 32'd0);
    clock_edge();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive_random();
      sample();
      clock_edge();
    end

    // fill regs 1..31, then asynchronous reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), $urandom, 0, 1, 5'($urandom_range(1, 31)), 5'(i), 5'(32 - i));
      sample();
      clock_edge();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i + 16);
      #1;
      check("async_rs1_data", rs1_data, 32'd0);
      check("async_rs2_data", rs2_data, 32'd0);
      check("async_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
    end
    check("async_count", wb_count, 32'd0);
    clock_edge();

    // commit held across reset release lands on first edge after deassertion
    drive(1, 12, 32'hC0FF_EE12, 0, 0, 0, 12, 0);
    sample();
    clock_edge();
    sample();
    rst = 1'b1;
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 12, 0);
    sample();
    check("post_reset_data", rs1_data, 32'hC0FF_EE12);
    check("post_reset_count", wb_count, 32'd1);
    clock_edge();

    for (int c = 0; c < 60; c++) begin
      drive_random();
      sample();
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; address width is log2(NREG) = 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Stall  input  1  pipeline stall; high = WB stage is holding its previous content.
REQ-006 SHALL have port wb_en  input  1  WB stage carries a register write.
REQ-007 SHALL have port wb_rd  input  5  WB destination register.
REQ-008 SHALL have port wb_data  input  DATA_W  WB write data.
REQ-009 SHALL have port iss_en  input  1  issue stage marks a new producer.
REQ-010 SHALL have port iss_rd  input  5  register being marked busy.
REQ-011 SHALL have ports rs1_addr and rs2_addr  input  5 each  read addresses.
REQ-012 SHALL have ports rs1_data and rs2_data  output  DATA_W each  read data.
REQ-013 SHALL have ports rs1_busy and rs2_busy  output  1 each  source has an outstanding producer.
REQ-014 SHALL have port wb_count  output  32  number of committed writes since reset.

Function
REQ-015 Commit condition SHALL be wb_en & ~Stall & (wb_rd != 0). Writes and busy-clears occur only on commit; a held WB value during Stall SHALL NOT commit again.
REQ-016 On commit, reg[wb_rd] SHALL take wb_data at the clock edge.
REQ-017 Reads SHALL be combinational; address 0 SHALL return 0.
REQ-018 Read bypass: when rsN_addr == wb_rd and commit is true in the same cycle, rsN_data SHALL equal wb_data.
REQ-019 Scoreboard: one busy bit per register. iss_en with iss_rd != 0 SHALL set busy[iss_rd]. Commit SHALL clear busy[wb_rd].
REQ-020 Simultaneous set and clear of the same register SHALL leave it busy, so the set wins.
REQ-021 busy[0] SHALL be constant 0; iss_rd == 0 SHALL be ignored.
REQ-022 rsN_busy SHALL be busy[rsN_addr] with a clear bypass: it SHALL be 0 if commit clears that register this cycle and no same-cycle set targets it.
REQ-023 iss_en SHALL be honoured regardless of Stall; the issue-side stall is the issuer's responsibility.
REQ-024 wb_count SHALL increment by 1 per commit, wrapping from 0xFFFFFFFF to 0.
REQ-025 Latency: a write is visible through the array 1 cycle after commit and through the bypass in the commit cycle.

Reset
REQ-026 While rst is low: all registers SHALL be 0, all busy bits 0, and wb_count 0, taking effect immediately without waiting for clk.
REQ-027 Outputs SHALL be 0 during reset. The only exception is rsN_data when commit is true, which follows REQ-018 because it is combinational.
REQ-028 Reset asserted mid-operation SHALL discard the pending commit and issue, with no partial write.
REQ-029 The first commit SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-030 A shared package SHALL hold REG_ADDR_W = 5, NREG, DATA_W, and the zero-register index constant.
REQ-031 The scoreboard SHALL be one sub-module, wb_scoreboard, containing the busy bits, set/clear priority, and busy bypass.
REQ-032 The register array, read/bypass muxes, commit logic, and counter SHALL reside in wb_regfile.

Verification
REQ-033 Write then read: commit wb_rd=5, wb_data=0xDEADBEEF; the same cycle rs1_addr=5 gives rs1_data=0xDEADBEEF through the bypass, and the next cycle, with wb_en=0, still gives 0xDEADBEEF; wb_count=1.
REQ-034 Stall hold: wb_en=1, wb_rd=7, wb_data=0x11, Stall=1 for 3 cycles, then Stall=0 for 1 cycle; reg7 is written once and wb_count increments by exactly 1.
REQ-035 x0 protection: commit wb_rd=0, wb_data=0xFFFFFFFF, and iss_en with iss_rd=0; rs1_addr=0 gives data 0 and busy 0; wb_count is unchanged.
REQ-036 Scoreboard race: busy[3]=1; same cycle iss_rd=3 and commit wb_rd=3; next cycle rs2_busy (rs2_addr=3) is 1 and reg3 holds the new wb_data.
REQ-037 Clear bypass: busy[9]=1, commit wb_rd=9; the same cycle rs1_busy=0 for rs1_addr=9, and the next cycle busy[9] stays 0.
REQ-038 Async reset: pull rst low mid-cycle after writes to regs 1..31; all reads return 0, all busy 0, and wb_count 0 before the next clk edge.
